// File: rtl/implication_queue_pkg.sv
// rtl/implication_queue_pkg.sv - sat_iq_pkg: shared entry/state types for the implication queue
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package sat_iq_pkg;

  localparam int IQ_VAR_BITS = `MAX_VARS_BITS;

  typedef struct packed {
    logic [IQ_VAR_BITS-1:0] var_idx;
    logic                   val;
  } iq_entry_t;

  typedef enum logic {
    IQ_RUN      = 1'b0,
    IQ_CONFLICT = 1'b1
  } iq_state_e;

endpackage

// File: rtl/implication_queue_if.sv
// rtl/implication_queue_if.sv - push/pop handshake bundle between evaluator, queue and trail logic
interface implication_queue_if #(
  parameter int VAR_BITS = sat_iq_pkg::IQ_VAR_BITS
);
  logic                push_valid;
  logic [VAR_BITS-1:0] push_var;
  logic                push_val;
  logic                push_ready;
  logic                pop_valid;
  logic [VAR_BITS-1:0] pop_var;
  logic                pop_val;
  logic                pop_ready;

  modport master (
    output push_valid, push_var, push_val, pop_ready,
    input  push_ready, pop_valid, pop_var, pop_val
  );

  modport slave (
    input  push_valid, push_var, push_val, pop_ready,
    output push_ready, pop_valid, pop_var, pop_val
  );
endinterface

// File: rtl/implication_queue_match_cam.sv
// rtl/implication_queue_match_cam.sv - iq_match_cam: parallel compare of a pushed variable
// against every valid queue entry.
module iq_match_cam
  import sat_iq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int VAR_BITS = IQ_VAR_BITS
) (
  input  logic [VAR_BITS-1:0]            i_var,
  input  logic [DEPTH-1:0]               i_valid,
  input  logic [DEPTH-1:0][VAR_BITS-1:0] i_mem_var,
  input  logic [DEPTH-1:0]               i_mem_val,
  output logic                           o_hit,
  output logic                           o_hit_val
);

  // A variable is held at most once, so at most one lane can match.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_val = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_valid[i] && (i_mem_var[i] == i_var)) begin
        o_hit     = 1'b1;
        o_hit_val = i_mem_val[i];
      end
    end
  end

endmodule

// File: rtl/implication_queue.sv
// rtl/implication_queue.sv - FWFT implication FIFO with duplicate drop and sticky conflict.
// Optional IQ_STATS_EN adds saturating push/dup/high-water statistics.
module implication_queue
  import sat_iq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int VAR_BITS = IQ_VAR_BITS
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  implication_queue_if.slave       bus,
  output logic                     o_conflict,
  output logic [VAR_BITS-1:0]      o_conflict_var,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef IQ_STATS_EN
  ,
  output logic [15:0]              o_stat_pushes,
  output logic [15:0]              o_stat_dups,
  output logic [15:0]              o_stat_hiwater
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  iq_state_e                     r_state;
  iq_state_e                     w_state_next;
  logic [PW-1:0]                 r_rd_ptr;
  logic [PW-1:0]                 r_wr_ptr;
  logic [CW-1:0]                 r_count;
  logic                          r_conflict;
  logic [VAR_BITS-1:0]           r_conflict_var;
  logic [DEPTH-1:0][VAR_BITS-1:0] r_mem_var;
  logic [DEPTH-1:0]              r_mem_val;

  logic                          w_run;
  logic                          w_push_ready;
  logic                          w_pop_valid;
  logic                          w_push_acc;
  logic                          w_pop;
  logic                          w_enq;
  logic                          w_dup;
  logic                          w_conf;
  logic                          w_hit;
  logic                          w_hit_val;
  logic [DEPTH-1:0]              w_valid;
  logic [PW-1:0]                 w_off;

  assign w_run        = (r_state == IQ_RUN);
  assign w_push_ready = w_run && (r_count != FULL_COUNT);
  assign w_pop_valid  = w_run && (r_count != '0);
  assign w_push_acc   = bus.push_valid && w_push_ready;
  assign w_pop        = w_pop_valid && bus.pop_ready;
  assign w_enq        = w_push_acc && !w_hit;
  assign w_dup        = w_push_acc && w_hit && (w_hit_val == bus.push_val);
  assign w_conf       = w_push_acc && w_hit && (w_hit_val != bus.push_val);

  // Slot i is live when its distance from the read pointer is below count;
  // this includes the head even when it is being popped this cycle.
  always_comb begin
    w_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PW'(i) - r_rd_ptr;
      w_valid[i] = ({1'b0, w_off} < r_count);
    end
  end

  iq_match_cam #(
    .DEPTH    (DEPTH),
    .VAR_BITS (VAR_BITS)
  ) u_cam (
    .i_var     (bus.push_var),
    .i_valid   (w_valid),
    .i_mem_var (r_mem_var),
    .i_mem_val (r_mem_val),
    .o_hit     (w_hit),
    .o_hit_val (w_hit_val)
  );

  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = IQ_RUN;
    end else if (w_conf) begin
      w_state_next = IQ_CONFLICT;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IQ_RUN;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_conflict     <= 1'b0;
      r_conflict_var <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_flush) begin
        r_rd_ptr       <= '0;
        r_wr_ptr       <= '0;
        r_count        <= '0;
        r_conflict     <= 1'b0;
        r_conflict_var <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_enq && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (!w_enq && w_pop) begin
          r_count <= r_count - 1'b1;
        end
        if (w_conf) begin
          r_conflict     <= 1'b1;
          r_conflict_var <= bus.push_var;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_enq && !i_flush) begin
      r_mem_var[r_wr_ptr] <= bus.push_var;
      r_mem_val[r_wr_ptr] <= bus.push_val;
    end
  end

`ifdef IQ_STATS_EN
  logic [15:0] r_stat_pushes;
  logic [15:0] r_stat_dups;
  logic [15:0] r_stat_hiwater;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_stat_pushes  <= '0;
      r_stat_dups    <= '0;
      r_stat_hiwater <= '0;
    end else begin
      if (w_push_acc && !i_flush && (r_stat_pushes != 16'hFFFF))
        r_stat_pushes <= r_stat_pushes + 1'b1;
      if (w_dup && !i_flush && (r_stat_dups != 16'hFFFF))
        r_stat_dups <= r_stat_dups + 1'b1;
      if (16'(r_count) > r_stat_hiwater)
        r_stat_hiwater <= 16'(r_count);
    end
  end

  assign o_stat_pushes  = r_stat_pushes;
  assign o_stat_dups    = r_stat_dups;
  assign o_stat_hiwater = r_stat_hiwater;
`endif

  assign bus.push_ready = w_push_ready;
  assign bus.pop_valid  = w_pop_valid;
  assign bus.pop_var    = w_pop_valid ? r_mem_var[r_rd_ptr] : '0;
  assign bus.pop_val    = w_pop_valid ? r_mem_val[r_rd_ptr] : 1'b0;
  assign o_conflict     = r_conflict;
  assign o_conflict_var = r_conflict_var;
  assign o_count        = r_count;

endmodule
